// File: rtl/cnn_eval_pkg.sv
// Shared types and defaults for the CNN batch evaluator and its record reader.
package cnn_eval_pkg;

  localparam int unsigned DEF_PIX_W   = 8;
  localparam int unsigned DEF_N_PIX   = 784;
  localparam int unsigned DEF_N_IMG   = 16;
  localparam int unsigned DEF_LABEL_W = 4;
  localparam int unsigned DEF_ADDR_W  = 14;
  localparam int unsigned DEF_TIMEOUT = 65535;

  localparam int unsigned DEF_NUM_W = $clog2(DEF_N_IMG + 1);
  localparam int unsigned DEF_IDX_W = $clog2(DEF_N_IMG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT,
    ST_SCORE,
    ST_DONE
  } state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned count_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cnn_eval_fetch.sv
// Record reader: streams one image record (N_PIX pixels + label word) out of a
// synchronous 1-cycle-latency memory into a flat pixel vector and a label.
module cnn_eval_fetch
  import cnn_eval_pkg::*;
#(
  parameter int unsigned PIX_W   = DEF_PIX_W,
  parameter int unsigned N_PIX   = DEF_N_PIX,
  parameter int unsigned LABEL_W = DEF_LABEL_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     go,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [PIX_W-1:0]         mem_rdata,
  output logic [PIX_W*N_PIX-1:0]   image_data,
  output logic [LABEL_W-1:0]       label,
  output logic                     fetch_done
);

  localparam int unsigned CNT_W = count_w(N_PIX);

  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] cap_idx;
  logic             cap_vld;
  logic             last_word;

  assign last_word = (word_cnt == CNT_W'(N_PIX));

  // Read issue; the address keeps running so the next record starts where this one ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      word_cnt   <= '0;
      fetch_done <= 1'b0;
    end else begin
      fetch_done <= mem_rd && last_word;
      if (clr) begin
        mem_addr <= '0;
      end else if (mem_rd) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (go) begin
        mem_rd   <= 1'b1;
        word_cnt <= '0;
      end else if (mem_rd) begin
        word_cnt <= word_cnt + CNT_W'(1);
        if (last_word) begin
          mem_rd <= 1'b0;
        end
      end
    end
  end

  // Pixels shift in from the top, so after N_PIX words pixel j sits in slot j.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      image_data <= '0;
      label      <= '0;
    end else begin
      cap_vld <= mem_rd;
      cap_idx <= word_cnt;
      if (cap_vld) begin
        if (cap_idx == CNT_W'(N_PIX)) begin
          label <= mem_rdata[LABEL_W-1:0];
        end else begin
          image_data <= {mem_rdata, image_data[PIX_W*N_PIX-1:PIX_W]};
        end
      end
    end
  end

endmodule

// File: rtl/cnn_batch_eval.sv
// Batch evaluator: runs cnn_top over stored image records and scores predictions.
// Optional per-image inference timeout enabled by defining CNN_EVAL_TIMEOUT_EN.
module cnn_batch_eval
  import cnn_eval_pkg::*;
#(
  parameter int unsigned PIX_W   = DEF_PIX_W,
  parameter int unsigned N_PIX   = DEF_N_PIX,
  parameter int unsigned N_IMG   = DEF_N_IMG,
  parameter int unsigned LABEL_W = DEF_LABEL_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
`ifdef CNN_EVAL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
`endif
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(N_IMG+1)-1:0]  num_images,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_rd,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [PIX_W-1:0]            mem_rdata,
  output logic [PIX_W*N_PIX-1:0]      cnn_image_data,
  output logic [LABEL_W-1:0]          cnn_label,
  output logic                        cnn_start,
  input  logic [LABEL_W-1:0]          cnn_classification,
  input  logic                        cnn_done,
  output logic [$clog2(N_IMG+1)-1:0]  correct_cnt,
  output logic [$clog2(N_IMG+1)-1:0]  total_cnt,
  output logic [$clog2(N_IMG)-1:0]    first_err_idx,
  output logic                        err_seen
`ifdef CNN_EVAL_TIMEOUT_EN
  ,
  output logic [$clog2(N_IMG+1)-1:0]  timeout_cnt
`endif
);

  localparam int unsigned NUM_W = count_w(N_IMG);
  localparam int unsigned IDX_W = $clog2(N_IMG);

  state_t           state;
  state_t           state_next;
  logic             fetch_go;
  logic             batch_clr;
  logic             fetch_done;
  logic             img_last;
  logic             miss;
  logic [NUM_W-1:0] img_idx;
  logic [NUM_W-1:0] n_target;
  logic [LABEL_W-1:0] pred;

`ifdef CNN_EVAL_TIMEOUT_EN
  localparam int unsigned TO_W = count_w(TIMEOUT);
  logic [TO_W-1:0] to_cnt;
  logic            timed_out;
  logic            to_hit;

  assign to_hit = (state == ST_WAIT) && (to_cnt == TO_W'(TIMEOUT - 1));
  assign miss   = timed_out || (pred != cnn_label);
`else
  assign miss   = (pred != cnn_label);
`endif

  assign img_last = ((img_idx + NUM_W'(1)) == n_target);

  cnn_eval_fetch #(
    .PIX_W   (PIX_W),
    .N_PIX   (N_PIX),
    .LABEL_W (LABEL_W),
    .ADDR_W  (ADDR_W)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (batch_clr),
    .go         (fetch_go),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .image_data (cnn_image_data),
    .label      (cnn_label),
    .fetch_done (fetch_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fetch_go   = 1'b0;
    batch_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          batch_clr = 1'b1;
          if (num_images == '0) begin
            state_next = ST_DONE;
          end else begin
            fetch_go   = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_FETCH:  if (fetch_done) state_next = ST_LAUNCH;
      ST_LAUNCH: state_next = ST_WAIT;
      ST_WAIT: begin
        if (cnn_done) begin
          state_next = ST_SCORE;
        end
`ifdef CNN_EVAL_TIMEOUT_EN
        else if (to_hit) begin
          state_next = ST_SCORE;
        end
`endif
      end
      ST_SCORE: begin
        if (img_last) begin
          state_next = ST_DONE;
        end else begin
          fetch_go   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnn_start <= 1'b0;
    end else begin
      busy      <= (state_next != ST_IDLE);
      done      <= (state_next == ST_DONE);
      cnn_start <= (state_next == ST_LAUNCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_idx       <= '0;
      n_target      <= '0;
      pred          <= '0;
      correct_cnt   <= '0;
      total_cnt     <= '0;
      first_err_idx <= '0;
      err_seen      <= 1'b0;
`ifdef CNN_EVAL_TIMEOUT_EN
      to_cnt        <= '0;
      timed_out     <= 1'b0;
      timeout_cnt   <= '0;
`endif
    end else begin
      if (batch_clr) begin
        img_idx       <= '0;
        n_target      <= (num_images > NUM_W'(N_IMG)) ? NUM_W'(N_IMG) : num_images;
        correct_cnt   <= '0;
        total_cnt     <= '0;
        first_err_idx <= '0;
        err_seen      <= 1'b0;
`ifdef CNN_EVAL_TIMEOUT_EN
        timeout_cnt   <= '0;
`endif
      end
      if ((state == ST_WAIT) && cnn_done) begin
        pred <= cnn_classification;
      end
`ifdef CNN_EVAL_TIMEOUT_EN
      if (state == ST_LAUNCH) begin
        to_cnt    <= '0;
        timed_out <= 1'b0;
      end else if (state == ST_WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (to_hit && !cnn_done) begin
          timed_out <= 1'b1;
        end
      end
`endif
      if (state == ST_SCORE) begin
        total_cnt <= total_cnt + NUM_W'(1);
        img_idx   <= img_idx + NUM_W'(1);
        if (!miss) begin
          correct_cnt <= correct_cnt + NUM_W'(1);
        end else if (!err_seen) begin
          err_seen      <= 1'b1;
          first_err_idx <= IDX_W'(img_idx);
        end
`ifdef CNN_EVAL_TIMEOUT_EN
        if (timed_out) begin
          timeout_cnt <= timeout_cnt + NUM_W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_cnn_batch_eval.sv
// Scoreboard bench for cnn_batch_eval: random records and CNN responses, reference
// model of the batch score, monitor comparing reads, launches and batch results.
module tb_cnn_batch_eval;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  num_images;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] cnn_image_data;
  logic [3:0]  cnn_label;
  logic        cnn_start;
  logic [3:0]  cnn_classification;
  logic        cnn_done;
  logic [2:0]  correct_cnt;
  logic [2:0]  total_cnt;
  logic [1:0]  first_err_idx;
  logic        err_seen;
`ifdef CNN_EVAL_TIMEOUT_EN
  logic [2:0]  timeout_cnt;
`endif

  cnn_batch_eval #(
    .PIX_W   (8),
    .N_PIX   (4),
    .N_IMG   (4),
    .LABEL_W (4),
    .ADDR_W  (6)
`ifdef CNN_EVAL_TIMEOUT_EN
    ,
    .TIMEOUT (10)
`endif
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .num_images         (num_images),
    .busy               (busy),
    .done               (done),
    .mem_rd             (mem_rd),
    .mem_addr           (mem_addr),
    .mem_rdata          (mem_rdata),
    .cnn_image_data     (cnn_image_data),
    .cnn_label          (cnn_label),
    .cnn_start          (cnn_start),
    .cnn_classification (cnn_classification),
    .cnn_done           (cnn_done),
    .correct_cnt        (correct_cnt),
    .total_cnt          (total_cnt),
    .first_err_idx      (first_err_idx),
    .err_seen           (err_seen)
`ifdef CNN_EVAL_TIMEOUT_EN
    ,
    .timeout_cnt        (timeout_cnt)
`endif
  );

  typedef struct {
    int correct;
    int total;
    int first;
    int err;
    int to;
  } res_t;

  typedef struct {
    logic [31:0] img;
    logic [3:0]  lbl;
  } launch_t;

  logic [7:0] mem [64];
  logic [3:0] resp [8];
  bit         mute [8];
  int         cnn_img;
  bit         stray_arm;
  int         lat_cnt;
  logic [3:0] pending;
  int         rd_run;
  int         n_cmp;
  int         n_bad;

  res_t    res_q[$];
  launch_t launch_q[$];
  int      addr_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image memory, one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // CNN model: fixed 3-cycle latency, response chosen per image; optional stray done.
  initial begin
    cnn_done = 1'b0;
    cnn_classification = '0;
    lat_cnt = 0;
    pending = '0;
    forever begin
      @(negedge clk);
      cnn_done = 1'b0;
      if (!rst_n) begin
        lat_cnt = 0;
      end else begin
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            cnn_done = 1'b1;
            cnn_classification = pending;
          end
        end
        if (stray_arm && mem_rd) begin
          cnn_done = 1'b1;
          cnn_classification = cnn_label ^ 4'hF;
          stray_arm = 1'b0;
        end
        if (cnn_start) begin
          if (!mute[cnn_img]) begin
            lat_cnt = 3;
            pending = resp[cnn_img];
          end
          cnn_img++;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT reads, launches or completes.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_run = 0;
    end else begin
      if (mem_rd) begin
        rd_run++;
        if (addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_rd: unexpected read at addr %0d", mem_addr);
        end else begin
          check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
      end else if (rd_run != 0) begin
        check("rd_burst_len", 64'(rd_run), 64'(5));
        rd_run = 0;
      end
      if (cnn_start) begin
        if (launch_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cnn_start: unexpected launch");
        end else begin
          launch_t l;
          l = launch_q.pop_front();
          check("cnn_image_data", 64'(cnn_image_data), 64'(l.img));
          check("cnn_label", 64'(cnn_label), 64'(l.lbl));
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done: unexpected done pulse");
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("correct_cnt", 64'(correct_cnt), 64'(r.correct));
          check("total_cnt", 64'(total_cnt), 64'(r.total));
          check("first_err_idx", 64'(first_err_idx), 64'(r.first));
          check("err_seen", 64'(err_seen), 64'(r.err));
          check("busy_at_done", 64'(busy), 64'(1));
`ifdef CNN_EVAL_TIMEOUT_EN
          check("timeout_cnt", 64'(timeout_cnt), 64'(r.to));
`endif
        end
      end
    end
  end

  // Reference model: expected reads, launches and batch score from memory and responses.
  task automatic push_expect(input int n_req);
    int n;
    int b;
    res_t r;
    launch_t l;
    n = (n_req > 4) ? 4 : n_req;
    r = '{0, 0, 0, 0, 0};
    for (int k = 0; k < n; k++) begin
      b = k * 5;
      l.img = {mem[b+3], mem[b+2], mem[b+1], mem[b]};
      l.lbl = mem[b+4][3:0];
      launch_q.push_back(l);
      for (int w = 0; w < 5; w++) addr_q.push_back(b + w);
      if (!mute[k] && resp[k] == l.lbl) r.correct++;
      else if (r.err == 0) begin
        r.err = 1;
        r.first = k;
      end
      if (mute[k]) r.to++;
    end
    r.total = n;
    res_q.push_back(r);
  endtask

  task automatic randomize_records(input bit echo_all);
    for (int a = 0; a < 20; a++) mem[a] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] lbl;
      lbl = mem[k*5+4][3:0];
      resp[k] = (echo_all || $urandom_range(0, 1) == 1) ? lbl : 4'($urandom);
      mute[k] = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic run_batch(input int n, input bit poke_busy, input bit stray);
    cnn_img = 0;
    stray_arm = stray;
    push_expect(n);
    @(negedge clk);
    start = 1'b1;
    num_images = 3'(n);
    @(negedge clk);
    start = 1'b0;
    num_images = '0;
    check("busy_after_start", 64'(busy), 64'(1));
    if (n == 0) check("done_num0_latency", 64'(done), 64'(1));
    if (poke_busy) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      num_images = 3'd1;
      @(negedge clk);
      start = 1'b0;
      num_images = '0;
    end
    wait_done(600);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_mem_rd"}, 64'(mem_rd), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_cnn_start"}, 64'(cnn_start), 64'(0));
    check({tag, "_image"}, 64'(cnn_image_data), 64'(0));
    check({tag, "_label"}, 64'(cnn_label), 64'(0));
    check({tag, "_correct"}, 64'(correct_cnt), 64'(0));
    check({tag, "_total"}, 64'(total_cnt), 64'(0));
    check({tag, "_first_err"}, 64'(first_err_idx), 64'(0));
    check({tag, "_err_seen"}, 64'(err_seen), 64'(0));
`ifdef CNN_EVAL_TIMEOUT_EN
    check({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'(0));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_cmp = 0;
    n_bad = 0;
    rd_run = 0;
    cnn_img = 0;
    stray_arm = 1'b0;
    start = 1'b0;
    num_images = '0;
    for (int a = 0; a < 64; a++) mem[a] = '0;
    for (int k = 0; k < 8; k++) begin
      resp[k] = '0;
      mute[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Perfect batch of 3 with a known first record, stray done and a start while busy.
    randomize_records(1'b1);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h09;
    resp[0] = 4'h9;
    run_batch(3, 1'b1, 1'b1);

    // Mismatch tracking.
    randomize_records(1'b1);
    mem[4] = 8'h02; mem[9] = 8'h05; mem[14] = 8'h07; mem[19] = 8'h01;
    resp[0] = 4'h2; resp[1] = 4'h6; resp[2] = 4'h7; resp[3] = 4'h0;
    run_batch(4, 1'b0, 1'b0);

    // Clamp and empty batch.
    randomize_records(1'b0);
    run_batch(7, 1'b0, 1'b0);
    run_batch(0, 1'b0, 1'b0);

    for (int it = 0; it < 6; it++) begin
      randomize_records(1'b0);
      run_batch(int'($urandom_range(0, 7)), 1'b0, it == 2);
    end

    // Reset during WAIT of image 2 aborts the batch without a done.
    randomize_records(1'b0);
    mem[4][3:0] = 4'h3;
    resp[0] = 4'h5;
    cnn_img = 0;
    push_expect(4);
    @(negedge clk);
    start = 1'b1;
    num_images = 3'd4;
    @(negedge clk);
    start = 1'b0;
    num_images = '0;
    seen = 0;
    for (int c = 0; c < 300 && seen < 3; c++) begin
      @(negedge clk);
      if (cnn_start) seen++;
    end
    check("mid_reset_launches", 64'(seen), 64'(3));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("mid_reset");
    addr_q.delete();
    launch_q.delete();
    res_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("no_done_in_reset", 64'(done), 64'(0));
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_reset", 64'(done), 64'(0));
    end
    randomize_records(1'b0);
    run_batch(4, 1'b0, 1'b0);

`ifdef CNN_EVAL_TIMEOUT_EN
    randomize_records(1'b1);
    mute[1] = 1'b1;
    run_batch(2, 1'b0, 1'b0);
    mute[1] = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("left_results", 64'(res_q.size()), 64'(0));
    check("left_launches", 64'(launch_q.size()), 64'(0));
    check("left_reads", 64'(addr_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnn_batch_eval.md
Name: cnn_batch_eval

Overview:
- Synthesizable batch evaluator that drives `cnn_top` over a set of stored images and scores its predictions on-chip.
- For each image it:
  - fetches the pixels and the label from a synchronous image memory;
  - presents the flattened image and pulses start;
  - waits for done;
  - compares the classification against the label and accumulates the results.
- Sits between the image/label RAM and `cnn_top`. It replaces simulation-only stimulus with a parametrised, multi-image, hardware-resident flow.

Parameters:
- PIX_W, 8, bits per pixel and per label word in memory
- N_PIX, 784, pixels per image (28x28)
- N_IMG, 16, maximum images per batch
- LABEL_W, 4, classification/label width
- ADDR_W, 14, image memory address width; must satisfy 2^ADDR_W >= N_IMG*(N_PIX+1)
- TIMEOUT, 65535, cycles allowed per inference; used only with the optional feature

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a batch
- num_images  in  clog2(N_IMG+1)  images to run in this batch, sampled on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at batch completion
- mem_rd  out  1  memory read enable
- mem_addr  out  ADDR_W  memory word address
- mem_rdata  in  PIX_W  read data, valid exactly 1 cycle after mem_rd
- cnn_image_data  out  PIX_W*N_PIX  flattened image; pixel i at [i*PIX_W +: PIX_W]
- cnn_label  out  LABEL_W  ground-truth label of the current image
- cnn_start  out  1  one-cycle pulse to the CNN
- cnn_classification  in  LABEL_W  CNN prediction, valid when cnn_done=1
- cnn_done  in  1  CNN completion pulse
- correct_cnt  out  clog2(N_IMG+1)  images classified correctly
- total_cnt  out  clog2(N_IMG+1)  images scored
- first_err_idx  out  clog2(N_IMG)  index of the first mismatched image
- err_seen  out  1  at least one mismatch in the batch

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - state=IDLE;
  - all outputs 0, including cnn_image_data, counters, first_err_idx and err_seen.
  - Reset mid-batch aborts the batch immediately; no done pulse is generated.
- **Memory layout:**
  - Each record is N_PIX+1 consecutive words: pixels 0..N_PIX-1, then the label word.
  - cnn_label takes the label word's low LABEL_W bits.
  - Record k starts at k*(N_PIX+1). The address is held in a running counter; no multiplier.
- **FSM: IDLE, FETCH, LAUNCH, WAIT, SCORE, DONE.**
  - IDLE: start=1 clears counters, err_seen and first_err_idx, sets img_idx=0 and addr=0.
    - If num_images==0, go to DONE.
    - Otherwise go to FETCH.
  - FETCH: issues reads for words 0..N_PIX of the record on consecutive cycles (mem_rd=1).
    - Word j is captured one cycle later: into pixel slot j for j<N_PIX, into cnn_label for j=N_PIX.
    - Occupancy is N_PIX+2 cycles; then go to LAUNCH.
  - LAUNCH: cnn_start=1 for exactly one cycle; go to WAIT.
    - cnn_image_data and cnn_label are stable from LAUNCH until the next FETCH begins.
  - WAIT: wait for cnn_done. On cnn_done, register cnn_classification and go to SCORE.
  - SCORE:
    - total_cnt++.
    - If the registered prediction equals cnn_label, correct_cnt++.
    - Otherwise, if err_seen==0, set first_err_idx=img_idx and err_seen=1.
    - Then img_idx++. If img_idx+1==num_images, go to DONE; else go to FETCH.
  - DONE: done=1 for one cycle; go to IDLE. Counters and err fields hold their values until the next start.
- **busy:** 1 in every state except IDLE.
- **Boundary rules:**
  - start while busy: ignored.
  - num_images > N_IMG: clamped to N_IMG.
  - cnn_done outside WAIT: ignored.
  - cnn_done in the same cycle as cnn_start: not possible to accept; only WAIT samples cnn_done.
  - Counters cannot overflow: maximum count is N_IMG.
- **Per-image latency:** N_PIX+2 (FETCH) + 1 (LAUNCH) + CNN latency + 1 (SCORE) cycles.

Optional Feature:
- Macro: CNN_EVAL_TIMEOUT_EN.
- Defined:
  - A per-image counter runs in WAIT.
  - If TIMEOUT cycles elapse without cnn_done, the image is scored as a mismatch: total_cnt++ and err fields updated as in SCORE.
  - An extra output `timeout_cnt` (width clog2(N_IMG+1), reset 0, cleared on start) increments.
  - The FSM proceeds as from SCORE.
- Undefined:
  - WAIT waits indefinitely.
  - No counter, no timeout_cnt port.

Decomposition:
- Shared package `cnn_eval_pkg`:
  - state enum;
  - clog2-derived width constants;
  - default N_PIX/PIX_W/LABEL_W matching `cnn_top`.
- One natural sub-module: `cnn_eval_fetch`, the record reader. It generates addresses, handles 1-cycle-latency capture into the pixel vector and label, and asserts fetch_done.

Test Plan:
- Use N_PIX=4, N_IMG=4 with a CNN model of fixed 3-cycle latency.
- Perfect batch: 3 records, CNN echoes label → correct_cnt=3, total_cnt=3, err_seen=0, one done pulse.
- Mismatch tracking: labels {2,5,7,1}, CNN returns {2,6,7,0} → correct_cnt=2, total_cnt=4, first_err_idx=1, err_seen=1.
- Data path: record 0 pixels {0x11,0x22,0x33,0x44}, label 0x09 → cnn_image_data=0x44332211 and cnn_label=9 at cnn_start; mem_addr steps 0..4 over 5 consecutive cycles.
- Edge cases:
  - num_images=0 → done one cycle after the start cycle's IDLE exit, counters 0;
  - start while busy → no effect;
  - stray cnn_done during FETCH → ignored.
- Reset mid-batch: rst_n low during WAIT of image 2 → all outputs 0 asynchronously, no done; a following start runs a full batch.
- With CNN_EVAL_TIMEOUT_EN, TIMEOUT=10, CNN never responds on image 1 of 2 → timeout_cnt=1, total_cnt=2, first_err_idx=1.
